// File: rtl/maj_vote_pkg.sv
// Shared types and elaboration helpers for the N-way majority voter and its
// per-channel health trackers.
package maj_vote_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAILED  = 2'd2
  } chan_state_e;

  // Width of a counter that must hold 0..fail_thr inclusive.
  function automatic int unsigned cc_width(input int unsigned fail_thr);
    return $clog2(fail_thr + 1);
  endfunction

  // Odd channel count (no vote ties) and a usable failure threshold.
  function automatic bit params_ok(input int unsigned n_ch, input int unsigned fail_thr);
    return ((n_ch % 2) == 1) && (n_ch >= 3) && (fail_thr >= 1);
  endfunction

endpackage

// File: rtl/maj_vote_chan_fsm.sv
// Per-channel health tracker: counts consecutive mismatching valid cycles and
// latches a sticky fault once the count reaches FAIL_THR.
module maj_vote_chan_fsm
  import maj_vote_pkg::*;
#(
  parameter int unsigned FAIL_THR = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  input  logic mismatch_i,
  input  logic clear_i,
  output logic fault_o
);

  localparam int unsigned     CC_W   = cc_width(FAIL_THR);
  localparam logic [CC_W-1:0] CC_ONE = CC_W'(1);
  localparam logic [CC_W-1:0] CC_THR = CC_W'(FAIL_THR);

  chan_state_e     state_q, state_d;
  logic [CC_W-1:0] cc_q, cc_d;
  logic            fault_q, fault_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_OK;
      cc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      fault_q <= fault_d;
    end
  end

  // Clear wins over any update; idle cycles leave count and state untouched.
  always_comb begin
    state_d = state_q;
    cc_d    = cc_q;
    if (clear_i) begin
      state_d = ST_OK;
      cc_d    = '0;
    end else if (valid_i) begin
      unique case (state_q)
        ST_OK: begin
          if (mismatch_i) begin
            cc_d    = CC_ONE;
            state_d = (CC_THR == CC_ONE) ? ST_FAILED : ST_SUSPECT;
          end
        end
        ST_SUSPECT: begin
          if (mismatch_i) begin
            cc_d = cc_q + CC_ONE;
            if ((cc_q + CC_ONE) == CC_THR) begin
              state_d = ST_FAILED;
            end
          end else begin
            cc_d    = '0;
            state_d = ST_OK;
          end
        end
        ST_FAILED: begin
          state_d = ST_FAILED;
        end
        default: begin
          state_d = ST_OK;
          cc_d    = '0;
        end
      endcase
    end
    fault_d = (state_d == ST_FAILED);
  end

  assign fault_o = fault_q;

endmodule

// File: rtl/maj_vote_seq.sv
// Registered N-way bitwise majority voter with per-channel disagreement flags,
// sticky channel fault tracking and a saturating error counter.
module maj_vote_seq
  import maj_vote_pkg::*;
#(
  parameter int unsigned N_CH     = 3,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned FAIL_THR = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    VALID_IN,
  input  logic [N_CH*WIDTH-1:0]   D,
  input  logic                    MODE,
  input  logic                    CLR_FAULT,
  output logic [WIDTH-1:0]        Z,
  output logic                    VALID_OUT,
  output logic [N_CH-1:0]         MISMATCH,
  output logic [N_CH-1:0]         FAULT,
  output logic                    NO_UNAN,
  output logic [CNT_W-1:0]        ERR_CNT
);

  if (!params_ok(N_CH, FAIL_THR)) begin : g_bad_params
    $error("maj_vote_seq: N_CH must be odd and >= 3, FAIL_THR must be >= 1");
  end

  localparam logic [CNT_W-1:0] ERR_MAX = '1;
  localparam logic [CNT_W-1:0] ERR_ONE = CNT_W'(1);

  logic [N_CH-1:0][WIDTH-1:0] chan_w;
  logic [WIDTH-1:0]           vote_c;
  logic [N_CH-1:0]            mism_c;
  logic [N_CH-1:0]            eq_c;
  logic                       all_eq_c;
  logic                       any_mism_c;

  logic [WIDTH-1:0] z_q, z_d;
  logic             valid_q, valid_d;
  logic [N_CH-1:0]  mism_q, mism_d;
  logic             no_unan_q, no_unan_d;
  logic [CNT_W-1:0] err_q, err_d;

  // Channel i sits at D[i*WIDTH +: WIDTH], which matches the packed layout.
  assign chan_w = D;

  // Column-wise population count; N_CH is odd so there is never a tie.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [N_CH-1:0] col;
    for (genvar i = 0; i < N_CH; i++) begin : g_col
      assign col[i] = chan_w[i][b];
    end
    assign vote_c[b] = ($countones(col) > (N_CH / 2));
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_cmp
    assign mism_c[i] = (chan_w[i] != vote_c);
    assign eq_c[i]   = (chan_w[i] == chan_w[0]);
  end

  assign all_eq_c   = &eq_c;
  assign any_mism_c = |mism_c;

  always_comb begin
    z_d       = z_q;
    valid_d   = VALID_IN;
    mism_d    = '0;
    no_unan_d = 1'b0;
    err_d     = err_q;
    if (VALID_IN) begin
      mism_d    = mism_c;
      no_unan_d = MODE && !all_eq_c;
      // Unanimous-only mode freezes Z whenever the channels disagree.
      if (!MODE || all_eq_c) begin
        z_d = vote_c;
      end
    end
    if (CLR_FAULT) begin
      err_d = '0;
    end else if (VALID_IN && any_mism_c && (err_q != ERR_MAX)) begin
      err_d = err_q + ERR_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      z_q       <= '0;
      valid_q   <= 1'b0;
      mism_q    <= '0;
      no_unan_q <= 1'b0;
      err_q     <= '0;
    end else begin
      z_q       <= z_d;
      valid_q   <= valid_d;
      mism_q    <= mism_d;
      no_unan_q <= no_unan_d;
      err_q     <= err_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    maj_vote_chan_fsm #(
      .FAIL_THR (FAIL_THR)
    ) u_chan_fsm (
      .clk_i      (CLK),
      .rst_ni     (RSTN),
      .valid_i    (VALID_IN),
      .mismatch_i (mism_c[i]),
      .clear_i    (CLR_FAULT),
      .fault_o    (FAULT[i])
    );
  end

  assign Z         = z_q;
  assign VALID_OUT = valid_q;
  assign MISMATCH  = mism_q;
  assign NO_UNAN   = no_unan_q;
  assign ERR_CNT   = err_q;

endmodule

// File: tb/tb_maj_vote_seq.sv
// Self-checking bench for maj_vote_seq: directed scenarios plus randomized
// traffic compared against a behavioural model of the voting/health rules.
module tb_maj_vote_seq;

  localparam int N_CH     = 3;
  localparam int WIDTH    = 8;
  localparam int FAIL_THR = 4;
  localparam int CNT_W    = 2;
  localparam int ERR_MAX  = (1 << CNT_W) - 1;

  logic                  CLK;
  logic                  RSTN;
  logic                  VALID_IN;
  logic [N_CH*WIDTH-1:0] D;
  logic                  MODE;
  logic                  CLR_FAULT;
  logic [WIDTH-1:0]      Z;
  logic                  VALID_OUT;
  logic [N_CH-1:0]       MISMATCH;
  logic [N_CH-1:0]       FAULT;
  logic                  NO_UNAN;
  logic [CNT_W-1:0]      ERR_CNT;

  int tests_run;
  int tests_failed;

  // Reference model state
  logic [WIDTH-1:0] m_z;
  logic             m_valid;
  logic [N_CH-1:0]  m_mism;
  logic             m_nounan;
  int               m_err;
  int               m_cc [N_CH];
  logic [N_CH-1:0]  m_failed;

  maj_vote_seq #(
    .N_CH     (N_CH),
    .WIDTH    (WIDTH),
    .FAIL_THR (FAIL_THR),
    .CNT_W    (CNT_W)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .VALID_IN  (VALID_IN),
    .D         (D),
    .MODE      (MODE),
    .CLR_FAULT (CLR_FAULT),
    .Z         (Z),
    .VALID_OUT (VALID_OUT),
    .MISMATCH  (MISMATCH),
    .FAULT     (FAULT),
    .NO_UNAN   (NO_UNAN),
    .ERR_CNT   (ERR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [N_CH*WIDTH-1:0] w3(input logic [7:0] c0, input logic [7:0] c1,
                                               input logic [7:0] c2);
    return {c2, c1, c0};
  endfunction

  task automatic model(input logic v, input logic [N_CH*WIDTH-1:0] d, input logic mode,
                       input logic clr, input logic rstn);
    logic [WIDTH-1:0] ch [N_CH];
    logic [WIDTH-1:0] vote;
    logic [N_CH-1:0]  mism;
    logic             alleq;
    int               ones;
    if (!rstn) begin
      m_z = '0; m_valid = 0; m_mism = '0; m_nounan = 0; m_err = 0; m_failed = '0;
      for (int i = 0; i < N_CH; i++) m_cc[i] = 0;
      return;
    end
    for (int i = 0; i < N_CH; i++) ch[i] = d[i*WIDTH +: WIDTH];
    for (int b = 0; b < WIDTH; b++) begin
      ones = 0;
      for (int i = 0; i < N_CH; i++) ones += int'(ch[i][b]);
      vote[b] = (2 * ones > N_CH);
    end
    alleq = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      mism[i] = (ch[i] != vote);
      if (ch[i] != ch[0]) alleq = 1'b0;
    end
    m_valid  = v;
    m_mism   = v ? mism : '0;
    m_nounan = v && mode && !alleq;
    if (v && (!mode || alleq)) m_z = vote;
    if (clr) begin
      m_err = 0; m_failed = '0;
      for (int i = 0; i < N_CH; i++) m_cc[i] = 0;
    end else if (v) begin
      if (mism != 0 && m_err < ERR_MAX) m_err++;
      for (int i = 0; i < N_CH; i++) begin
        if (m_failed[i]) continue;
        if (mism[i]) begin
          m_cc[i]++;
          if (m_cc[i] >= FAIL_THR) m_failed[i] = 1'b1;
        end else begin
          m_cc[i] = 0;
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [N_CH*WIDTH-1:0] d, input logic mode,
                      input logic clr, input logic rstn);
    VALID_IN = v; D = d; MODE = mode; CLR_FAULT = clr; RSTN = rstn;
    @(posedge CLK);
    #1;
    model(v, d, mode, clr, rstn);
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    step(1'b1, w3(8'h12, 8'h34, 8'h56), 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({Z, VALID_OUT, MISMATCH, FAULT, NO_UNAN, ERR_CNT} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got Z=%h V=%b M=%b F=%b NU=%b E=%0d, expected all 0",
               Z, VALID_OUT, MISMATCH, FAULT, NO_UNAN, ERR_CNT);
    end
  endtask

  task automatic test_basic_vote();
    do_reset();
    step(1'b1, w3(8'hA5, 8'hA5, 8'h5A), 1'b0, 1'b0, 1'b1);
    tests_run++;
    if ({Z, VALID_OUT, MISMATCH, NO_UNAN, ERR_CNT} !== {8'hA5, 1'b1, 3'b100, 1'b0, 2'd1}) begin
      tests_failed++;
      $display("FAIL basic_vote: got Z=%h V=%b M=%b NU=%b E=%0d, expected Z=a5 V=1 M=100 NU=0 E=1",
               Z, VALID_OUT, MISMATCH, NO_UNAN, ERR_CNT);
    end
    step(1'b0, w3(8'h00, 8'hFF, 8'h00), 1'b0, 1'b0, 1'b1);
    tests_run++;
    if ({Z, VALID_OUT, MISMATCH, NO_UNAN, ERR_CNT} !== {8'hA5, 1'b0, 3'b000, 1'b0, 2'd1}) begin
      tests_failed++;
      $display("FAIL idle_hold: got Z=%h V=%b M=%b NU=%b E=%0d, expected Z=a5 V=0 M=000 NU=0 E=1",
               Z, VALID_OUT, MISMATCH, NO_UNAN, ERR_CNT);
    end
  endtask

  task automatic test_bitwise_split();
    do_reset();
    step(1'b1, w3(8'hF0, 8'hCC, 8'hAA), 1'b0, 1'b0, 1'b1);
    tests_run++;
    if ({Z, VALID_OUT, MISMATCH, ERR_CNT} !== {8'hE8, 1'b1, 3'b111, 2'd1}) begin
      tests_failed++;
      $display("FAIL bitwise_split: got Z=%h V=%b M=%b E=%0d, expected Z=e8 V=1 M=111 E=1",
               Z, VALID_OUT, MISMATCH, ERR_CNT);
    end
  endtask

  task automatic test_fault_fsm();
    logic [N_CH*WIDTH-1:0] wg;
    logic [N_CH*WIDTH-1:0] wb;
    logic [N_CH-1:0]       exp_f;
    wg = w3(8'h3C, 8'h3C, 8'h3C);
    wb = w3(8'h3C, 8'h3D, 8'h3C);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, wb, 1'b0, 1'b0, 1'b1);
      tests_run++;
      if ({FAULT, MISMATCH} !== {3'b000, 3'b010}) begin
        tests_failed++;
        $display("FAIL fsm_first_run[%0d]: got F=%b M=%b, expected F=000 M=010", k, FAULT, MISMATCH);
      end
    end
    step(1'b1, wg, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if ({FAULT, MISMATCH} !== 6'b000_000) begin
      tests_failed++;
      $display("FAIL fsm_match: got F=%b M=%b, expected F=000 M=000", FAULT, MISMATCH);
    end
    // Second run with an idle gap: idle cycles must not reset the count.
    for (int k = 0; k < 5; k++) begin
      step(k != 2, wb, 1'b0, 1'b0, 1'b1);
      exp_f = (k == 4) ? 3'b010 : 3'b000;
      tests_run++;
      if (FAULT !== exp_f) begin
        tests_failed++;
        $display("FAIL fsm_second_run[%0d]: got F=%b, expected F=%b", k, FAULT, exp_f);
      end
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b1, wg, 1'b0, 1'b0, 1'b1);
      tests_run++;
      if ({FAULT, MISMATCH, ERR_CNT} !== {3'b010, 3'b000, 2'd3}) begin
        tests_failed++;
        $display("FAIL fsm_sticky[%0d]: got F=%b M=%b E=%0d, expected F=010 M=000 E=3",
                 k, FAULT, MISMATCH, ERR_CNT);
      end
    end
  endtask

  task automatic test_mode_unanimous();
    do_reset();
    step(1'b1, w3(8'h11, 8'h11, 8'h11), 1'b1, 1'b0, 1'b1);
    tests_run++;
    if ({Z, NO_UNAN, VALID_OUT} !== {8'h11, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL unan_set: got Z=%h NU=%b V=%b, expected Z=11 NU=0 V=1", Z, NO_UNAN, VALID_OUT);
    end
    step(1'b1, w3(8'h22, 8'h22, 8'h33), 1'b1, 1'b0, 1'b1);
    tests_run++;
    if ({Z, NO_UNAN, MISMATCH, VALID_OUT} !== {8'h11, 1'b1, 3'b100, 1'b1}) begin
      tests_failed++;
      $display("FAIL unan_hold: got Z=%h NU=%b M=%b V=%b, expected Z=11 NU=1 M=100 V=1",
               Z, NO_UNAN, MISMATCH, VALID_OUT);
    end
    step(1'b1, w3(8'h22, 8'h22, 8'h22), 1'b1, 1'b0, 1'b1);
    tests_run++;
    if ({Z, NO_UNAN, MISMATCH} !== {8'h22, 1'b0, 3'b000}) begin
      tests_failed++;
      $display("FAIL unan_update: got Z=%h NU=%b M=%b, expected Z=22 NU=0 M=000", Z, NO_UNAN, MISMATCH);
    end
  endtask

  task automatic test_sat_and_clear();
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, w3(8'h5A, 8'h00, 8'h00), 1'b0, 1'b0, 1'b1);
    tests_run++;
    if ({ERR_CNT, FAULT} !== {2'd3, 3'b001}) begin
      tests_failed++;
      $display("FAIL err_saturate: got E=%0d F=%b, expected E=3 F=001", ERR_CNT, FAULT);
    end
    step(1'b1, w3(8'h10, 8'h10, 8'h99), 1'b0, 1'b1, 1'b1);
    tests_run++;
    if ({ERR_CNT, FAULT, Z, MISMATCH, VALID_OUT} !== {2'd0, 3'b000, 8'h10, 3'b100, 1'b1}) begin
      tests_failed++;
      $display("FAIL clear_with_vote: got E=%0d F=%b Z=%h M=%b V=%b, expected E=0 F=000 Z=10 M=100 V=1",
               ERR_CNT, FAULT, Z, MISMATCH, VALID_OUT);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, w3(8'h40, 8'h41, 8'h40), 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (FAULT !== 3'b010) begin
      tests_failed++;
      $display("FAIL pre_reset_fault: got F=%b, expected F=010", FAULT);
    end
    step(1'b1, w3(8'h77, 8'h77, 8'h77), 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({Z, VALID_OUT, MISMATCH, FAULT, NO_UNAN, ERR_CNT} !== '0) begin
      tests_failed++;
      $display("FAIL midstream_reset: got Z=%h V=%b M=%b F=%b NU=%b E=%0d, expected all 0",
               Z, VALID_OUT, MISMATCH, FAULT, NO_UNAN, ERR_CNT);
    end
    step(1'b0, w3(8'h77, 8'h77, 8'h77), 1'b0, 1'b0, 1'b1);
    tests_run++;
    if ({Z, VALID_OUT} !== {8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_word_dropped: got Z=%h V=%b, expected Z=00 V=0", Z, VALID_OUT);
    end
    step(1'b1, w3(8'h66, 8'h66, 8'h66), 1'b0, 1'b0, 1'b1);
    tests_run++;
    if ({Z, VALID_OUT} !== {8'h66, 1'b1}) begin
      tests_failed++;
      $display("FAIL first_after_reset: got Z=%h V=%b, expected Z=66 V=1", Z, VALID_OUT);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0]      base;
    logic [WIDTH-1:0]      chw [N_CH];
    logic [N_CH*WIDTH-1:0] d;
    logic                  v, mode, clr, rstn;
    logic [WIDTH+2*N_CH+CNT_W+1:0] got, exp;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      base = WIDTH'($urandom);
      for (int i = 0; i < N_CH; i++)
        chw[i] = ($urandom_range(0, 4) == 0) ? (base ^ WIDTH'($urandom_range(1, 255))) : base;
      d    = w3(chw[0], chw[1], chw[2]);
      v    = ($urandom_range(0, 3) != 0);
      mode = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 39) == 0);
      rstn = ($urandom_range(0, 99) != 0);
      step(v, d, mode, clr, rstn);
      got = {Z, VALID_OUT, MISMATCH, FAULT, NO_UNAN, ERR_CNT};
      exp = {m_z, m_valid, m_mism, m_failed, m_nounan, CNT_W'(m_err)};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL random_cycle[%0d]: got Z=%h V=%b M=%b F=%b NU=%b E=%0d, expected Z=%h V=%b M=%b F=%b NU=%b E=%0d",
                 n, Z, VALID_OUT, MISMATCH, FAULT, NO_UNAN, ERR_CNT,
                 m_z, m_valid, m_mism, m_failed, m_nounan, m_err);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    RSTN = 1'b0; VALID_IN = 1'b0; D = '0; MODE = 1'b0; CLR_FAULT = 1'b0;
    model(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    test_basic_vote();
    test_bitwise_split();
    test_fault_fsm();
    test_mode_unanimous();
    test_sat_and_clear();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
